// File: rtl/fft_io_pkg.sv
//==============================================================================
// Module  : fft_io_pkg
// Brief   : Shared byte-width constant and serializer state encoding.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package fft_io_pkg;

    localparam int BYTE_W = 8;

    // CSUM is only reachable when the checksum byte is built in.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CSUM  = 2'd2
    } ser_state_t;

endpackage

`default_nettype wire

// File: rtl/fft_result_serializer.sv
//==============================================================================
// Module  : fft_result_serializer
// Brief   : Drains a WORDS-byte result word LSB byte first over a valid/ready
//           byte bus. Macro FFT_SER_CHECKSUM_EN appends an XOR checksum byte.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module fft_result_serializer
    import fft_io_pkg::*;
#(
    parameter int WORDS = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [BYTE_W*WORDS-1:0]   load_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BYTE_W-1:0]         out_data,
    output logic                      out_last,
    output logic                      busy
);

    localparam int CNT_W = $clog2(WORDS + 1);
    localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(WORDS - 1);

    ser_state_t                 r_state;
    ser_state_t                 w_next_state;
    logic [BYTE_W*WORDS-1:0]    r_shift;
    logic [CNT_W-1:0]           r_index;
    logic                       w_load;
    logic                       w_byte_xfer;
    logic                       w_at_last;

    assign w_load      = load_valid && (r_state == IDLE);
    assign w_byte_xfer = out_ready && (r_state == SHIFT);
    assign w_at_last   = (r_index == c_last_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Shift register empties to zero as bytes leave, so out_data idles at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_index <= '0;
        end else if (w_load) begin
            r_shift <= load_data;
            r_index <= '0;
        end else if (w_byte_xfer) begin
            r_shift <= r_shift >> BYTE_W;
            r_index <= r_index + CNT_W'(1);
        end
    end

`ifdef FFT_SER_CHECKSUM_EN
    logic [BYTE_W-1:0] r_csum;

    always_ff @(posedge clk) begin
        if (rst || w_load) begin
            r_csum <= '0;
        end else if (w_byte_xfer) begin
            r_csum <= r_csum ^ r_shift[BYTE_W-1:0];
        end
    end
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (load_valid) begin
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (out_ready && w_at_last) begin
`ifdef FFT_SER_CHECKSUM_EN
                    w_next_state = CSUM;
`else
                    w_next_state = IDLE;
`endif
                end
            end
            CSUM: begin
`ifdef FFT_SER_CHECKSUM_EN
                if (out_ready) begin
                    w_next_state = IDLE;
                end
`else
                w_next_state = IDLE;
`endif
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        load_ready = 1'b0;
        busy       = 1'b1;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_data   = r_shift[BYTE_W-1:0];
        case (r_state)
            IDLE: begin
                load_ready = 1'b1;
                busy       = 1'b0;
            end
            SHIFT: begin
                out_valid = 1'b1;
`ifdef FFT_SER_CHECKSUM_EN
                out_last  = 1'b0;
`else
                out_last  = w_at_last;
`endif
            end
            CSUM: begin
`ifdef FFT_SER_CHECKSUM_EN
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_data  = r_csum;
`endif
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire
